// File: rtl/fix_trailer_gen_if.sv
// Byte-stream bundle between the message composer, the trailer generator
// and the TX framing stage. The slave modport is the trailer generator's view.
interface fix_trailer_gen_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_start;
    logic       in_end;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  in_data, in_valid, in_start, in_end,
        output in_ready,
        output out_data, out_valid,
        input  out_ready
    );

    modport master (
        output in_data, in_valid, in_start, in_end,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready
    );
endinterface

// File: rtl/fix_trailer_gen.sv
// FIX trailer generator: forwards a message body unchanged, sums the body
// bytes mod 256 and appends the trailer "10=DDD<SOH>" as seven ASCII bytes.
// The output stage is a single registered slot; the trailer follows the last
// body byte without bubbles when the downstream stays ready.
module fix_trailer_gen #(
    parameter logic [7:0] SOH    = 8'h01,
    parameter logic [7:0] TAG_HI = 8'h31,
    parameter logic [7:0] TAG_LO = 8'h30
) (
    input  logic                  clk,
    input  logic                  rst,
    fix_trailer_gen_if.slave      bus,
    output logic [7:0]            checksum_o,
    output logic                  checksum_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_TRAILER
    } state_t;

    state_t     r_state;
    logic [7:0] r_sum;
    logic [2:0] r_idx;        // trailer bytes loaded so far (0..7)
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic [7:0] r_checksum;
    logic       r_chk_valid;

    logic       w_out_free;
    logic       w_in_ready;
    logic       w_in_xfer;
    logic [7:0] w_sum_next;
    logic [7:0] w_hund;
    logic [7:0] w_rem;
    logic [7:0] w_tens;
    logic [7:0] w_units;
    logic [7:0] w_trl_byte;

    // The output slot can take a new byte when empty or being drained now.
    assign w_out_free = !r_out_valid || bus.out_ready;
    // NOTE: gating with rst keeps in_ready low while reset is held, even though
    // the registered state already looks like an empty IDLE.
    assign w_in_ready = rst && (r_state != S_TRAILER) && w_out_free;
    assign w_in_xfer  = bus.in_valid && w_in_ready;

    // A message's first byte restarts the sum; later bytes accumulate mod 256.
    assign w_sum_next = (r_state == S_IDLE) ? bus.in_data : r_sum + bus.in_data;

    // r_sum is frozen while in TRAILER, so the digits are stable there.
    assign w_hund  = r_sum / 8'd100;
    assign w_rem   = r_sum % 8'd100;
    assign w_tens  = w_rem / 8'd10;
    assign w_units = r_sum % 8'd10;

    // Select the next trailer byte to load into the output slot.
    always_comb begin
        // NOTE: default first so every path assigns w_trl_byte (no latch).
        w_trl_byte = SOH;
        case (r_idx)
            3'd0:    w_trl_byte = TAG_HI;
            3'd1:    w_trl_byte = TAG_LO;
            3'd2:    w_trl_byte = 8'h3D;
            3'd3:    w_trl_byte = 8'h30 + w_hund;
            3'd4:    w_trl_byte = 8'h30 + w_tens;
            3'd5:    w_trl_byte = 8'h30 + w_units;
            default: w_trl_byte = SOH;
        endcase
    end

    // Message FSM with the registered output slot and checksum report.
    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sum       <= 8'h00;
            r_idx       <= 3'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_checksum  <= 8'h00;
            r_chk_valid <= 1'b0;
        end else begin
            r_chk_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_BODY: begin
                    if (w_out_free) begin
                        r_out_valid <= 1'b0;
                    end
                    // In IDLE only a start-flagged byte opens a message;
                    // anything else is consumed and dropped.
                    if (w_in_xfer && (r_state == S_BODY || bus.in_start)) begin
                        r_out_data  <= bus.in_data;
                        r_out_valid <= 1'b1;
                        r_sum       <= w_sum_next;
                        r_idx       <= 3'd0;
                        r_state     <= bus.in_end ? S_TRAILER : S_BODY;
                    end
                end
                S_TRAILER: begin
                    if (w_out_free) begin
                        if (r_idx != 3'd7) begin
                            r_out_data  <= w_trl_byte;
                            r_out_valid <= 1'b1;
                            r_idx       <= r_idx + 3'd1;
                        end else begin
                            // The SOH in the slot is being accepted now.
                            r_out_valid <= 1'b0;
                            r_checksum  <= r_sum;
                            r_chk_valid <= 1'b1;
                            r_sum       <= 8'h00;
                            r_idx       <= 3'd0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_data      = r_out_data;
    assign bus.out_valid     = r_out_valid;
    assign checksum_o        = r_checksum;
    assign checksum_valid_o  = r_chk_valid;

endmodule

// File: tb/tb_fix_trailer_gen.sv
// Self-checking bench for fix_trailer_gen. Expected streams are built from the
// message bodies: body bytes, then "10=" + three decimal digits + SOH.
module tb_fix_trailer_gen;

    typedef logic [7:0] byte_q_t[$];
    typedef int         int_q_t[$];

    logic       clk;
    logic       rst;
    logic [7:0] checksum_o;
    logic       checksum_valid_o;

    fix_trailer_gen_if bus ();

    fix_trailer_gen #(
        .SOH    (8'h01),
        .TAG_HI (8'h31),
        .TAG_LO (8'h30)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .checksum_o       (checksum_o),
        .checksum_valid_o (checksum_valid_o)
    );

    int checks = 0;
    int errors = 0;

    // Timing records from the most recent run_msgs call.
    int q_soh_cyc[$];
    int q_start_cyc[$];
    int q_out_cyc[$];
    int q_soh_pos[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a sequence of messages and compare everything observed against
    // the reference stream. rmode: 0 ready always, 1 pattern 1,0,0, 2 random.
    task automatic run_msgs(input byte_q_t body, input int_q_t lens,
                            input int rmode, input int gap_pct, input string name);
        byte_q_t exp_out;
        byte_q_t got;
        int      exp_sum[$];
        int      pulse_val[$];
        int      pulse_cyc[$];
        bit      is_start[$];
        bit      is_end[$];
        int      base = 0;
        int      ip = 0;
        int      pulses = 0;
        int      tail = 0;
        int      cyc = 0;
        bit      prev_stall = 0;
        logic [7:0] prev_data = 8'h00;

        q_soh_cyc.delete(); q_start_cyc.delete(); q_out_cyc.delete(); q_soh_pos.delete();

        for (int m = 0; m < lens.size(); m++) begin
            int    s = 0;
            string str;
            for (int i = 0; i < lens[m]; i++) begin
                exp_out.push_back(body[base + i]);
                s += int'(body[base + i]);
                is_start.push_back(i == 0);
                is_end.push_back(i == lens[m] - 1);
            end
            s = s % 256;
            str = $sformatf("10=%03d", s);
            for (int j = 0; j < 6; j++) exp_out.push_back(str[j]);
            exp_out.push_back(8'h01);
            q_soh_pos.push_back(exp_out.size() - 1);
            exp_sum.push_back(s);
            base += lens[m];
        end

        while (cyc < 5000 && !(pulses == lens.size() && tail >= 3)) begin
            bus.in_valid  = (ip < body.size()) && ($urandom_range(99) >= gap_pct);
            bus.in_data   = (ip < body.size()) ? body[ip] : 8'($urandom);
            bus.in_start  = (ip < body.size()) ? is_start[ip] : 1'($urandom);
            bus.in_end    = (ip < body.size()) ? is_end[ip] : 1'($urandom);
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 3 == 0);
                default: bus.out_ready = ($urandom_range(99) < 60);
            endcase
            #1;
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                    errors++;
                    $display("FAIL %s stall_hold valid=%b data=%h exp valid=1 data=%h",
                             name, bus.out_valid, bus.out_data, prev_data);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in_ready_stall got %b exp 0", name, bus.in_ready);
                end
            end
            if (checksum_valid_o === 1'b1) begin
                pulses++;
                pulse_val.push_back(int'(checksum_o));
                pulse_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                if (is_start[ip]) q_start_cyc.push_back(cyc);
                ip++;
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                q_out_cyc.push_back(cyc);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (pulses == lens.size()) tail++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        checks++;
        if (pulses != lens.size()) begin
            errors++;
            $display("FAIL %s pulse_count got %0d exp %0d", name, pulses, lens.size());
        end
        checks++;
        if (got.size() != exp_out.size()) begin
            errors++;
            $display("FAIL %s out_len got %0d exp %0d", name, got.size(), exp_out.size());
        end
        for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
            checks++;
            if (got[i] !== exp_out[i]) begin
                errors++;
                $display("FAIL %s out_byte[%0d] got %h exp %h", name, i, got[i], exp_out[i]);
            end
        end
        for (int k = 0; k < pulses && k < lens.size(); k++) begin
            checks++;
            if (pulse_val[k] != exp_sum[k]) begin
                errors++;
                $display("FAIL %s checksum[%0d] got %h exp %h", name, k, pulse_val[k], exp_sum[k]);
            end
            if (q_soh_pos[k] < q_out_cyc.size()) begin
                q_soh_cyc.push_back(q_out_cyc[q_soh_pos[k]]);
                checks++;
                if (pulse_cyc[k] != q_out_cyc[q_soh_pos[k]] + 1) begin
                    errors++;
                    $display("FAIL %s pulse_timing[%0d] got %0d exp %0d", name, k,
                             pulse_cyc[k], q_out_cyc[q_soh_pos[k]] + 1);
                end
            end
        end
    endtask

    // With ready held high the whole message streams on consecutive cycles.
    task automatic check_no_bubble(input int n_out, input string name);
        checks++;
        if (q_out_cyc.size() != n_out ||
            q_out_cyc[q_out_cyc.size() - 1] - q_out_cyc[0] != n_out - 1) begin
            errors++;
            $display("FAIL %s no_bubble span got %0d exp %0d", name,
                     (q_out_cyc.size() > 0) ? q_out_cyc[q_out_cyc.size() - 1] - q_out_cyc[0] : -1,
                     n_out - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_start = 1'b1; bus.in_end = 1'b0;
        bus.in_data = 8'hA5; bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs in_ready=%b out_valid=%b out_data=%h exp 0 0 00",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        checks++;
        if (checksum_o !== 8'h00 || checksum_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_checksum got %h/%b exp 00/0", checksum_o, checksum_valid_o);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        run_msgs('{8'h01}, '{1}, 0, 0, "single");
        check_no_bubble(8, "single");
    endtask

    task automatic test_ab();
        run_msgs('{8'h41, 8'h42, 8'h01}, '{3}, 0, 0, "ab");
        check_no_bubble(10, "ab");
    endtask

    task automatic test_wrap();
        run_msgs('{8'hFF, 8'hFF, 8'h04}, '{3}, 0, 0, "wrap");
    endtask

    task automatic test_backpressure();
        run_msgs('{8'h41, 8'h42, 8'h01}, '{3}, 1, 0, "backpressure");
    endtask

    task automatic test_random();
        byte_q_t body;
        int_q_t  lens;
        for (int m = 0; m < 20; m++) begin
            int n = $urandom_range(1, 12);
            lens.push_back(n);
            for (int i = 0; i < n; i++) body.push_back(8'($urandom));
        end
        run_msgs(body, lens, 2, 30, "random");
    endtask

    task automatic test_stray_back_to_back();
        bus.in_valid = 1'b1; bus.in_start = 1'b0; bus.in_end = 1'b0;
        bus.in_data = 8'h55; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_ready got %b exp 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_forwarded out_valid got %b exp 0", bus.out_valid);
        end
        @(negedge clk);
        run_msgs('{8'h41, 8'h42, 8'h01, 8'h10, 8'h20, 8'h30}, '{3, 3}, 0, 0, "b2b");
        checks++;
        if (q_start_cyc.size() != 2 || q_soh_cyc.size() < 1 ||
            q_start_cyc[1] - q_soh_cyc[0] != 1) begin
            errors++;
            $display("FAIL b2b_start_gap got %0d exp 1",
                     (q_start_cyc.size() == 2 && q_soh_cyc.size() > 0) ?
                     q_start_cyc[1] - q_soh_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_trailer();
        byte_q_t body = '{8'h41, 8'h42, 8'h01};
        int      ip = 0;
        int      xfers = 0;
        int      cyc = 0;
        bus.out_ready = 1'b1;
        while (xfers < 6 && cyc < 50) begin
            bus.in_valid = (ip < 3);
            bus.in_data  = (ip < 3) ? body[ip] : 8'h00;
            bus.in_start = (ip == 0);
            bus.in_end   = (ip == 2);
            #1;
            if (bus.in_valid && bus.in_ready) ip++;
            if (bus.out_valid && bus.out_ready) xfers++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (xfers != 6 || bus.out_data !== 8'h31 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_trailer_setup xfers=%0d data=%h exp 6 31", xfers, bus.out_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || checksum_o !== 8'h00 || checksum_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_trailer_clear out_valid=%b checksum=%h pulse=%b exp 0 00 0",
                     bus.out_valid, checksum_o, checksum_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (checksum_valid_o !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_trailer_quiet pulse=%b out_valid=%b exp 0 0",
                         checksum_valid_o, bus.out_valid);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        run_msgs('{8'h46, 8'h49, 8'h58, 8'h01}, '{4}, 2, 20, "after_reset");
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_start = 1'b0; bus.in_end = 1'b0;
        bus.in_data = 8'h00; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_ab();
        test_wrap();
        test_backpressure();
        test_random();
        test_stray_back_to_back();
        test_reset_trailer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fix_trailer_gen.md
Name: fix_trailer_gen

Overview:
- Transmit-side counterpart of the receive checksum block.
- Accepts an outgoing FIX message body as a byte stream and forwards it unchanged.
- Computes the FIX checksum (sum of all body bytes mod 256) and then emits the standard trailer "10=DDD<SOH>" as 7 ASCII bytes.
- Sits between the message composer and the TX framing/MAC interface.

Parameters:
- SOH, 8'h01, field delimiter appended as the final trailer byte.
- TAG_HI, 8'h31, first trailer tag character ('1').
- TAG_LO, 8'h30, second trailer tag character ('0').

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  body byte.
- in_valid  input  1  in_data valid.
- in_start  input  1  first byte of message (qualified by in_valid).
- in_end  input  1  last body byte of message (qualified by in_valid).
- in_ready  output  1  block accepts byte this cycle.
- out_data  output  8  transmitted byte (body or trailer).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts byte this cycle.
- checksum_o  output  8  checksum of the last completed message.
- checksum_valid_o  output  1  one-cycle pulse when the trailer's final SOH is accepted downstream.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; sum=0; trailer index=0.
  - out_valid=0, out_data=0, in_ready=0 while reset is asserted.
  - checksum_o=0, checksum_valid_o=0.
- Handshakes:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - out_data/out_valid are registered, so a body byte appears on out_data 1 cycle after its input transfer.
  - Output holds stable while out_valid&!out_ready.
- in_ready = (state==IDLE or BODY) & (!out_valid | out_ready). It is 0 throughout TRAILER.
- States:
  - IDLE:
    - Input transfer with in_start=1: forward the byte; sum <= in_data.
    - If in_end=1 on the same beat, go to TRAILER; else go to BODY.
    - Input transfer with in_start=0: byte is consumed and dropped (not forwarded); state stays IDLE.
  - BODY:
    - Each input transfer: forward the byte; sum <= sum + in_data (8-bit, wraps mod 256).
    - in_end=1 on that beat: go to TRAILER.
    - in_start=1 while in BODY is ignored (treated as a data byte).
  - TRAILER:
    - On entry, the final sum is latched and split into ASCII digits: H=0x30+sum/100, T=0x30+(sum/100 remainder)/10, U=0x30+sum%10.
    - Trailer sequence, index 0..6: TAG_HI, TAG_LO, 0x3D('='), H, T, U, SOH.
    - The first trailer byte is loaded into the output register on the cycle the body's last byte is transferred out (or immediately if the output register is free).
    - Index advances only on output transfer.
    - On transfer of index 6: checksum_o <= sum; checksum_valid_o=1 for that cycle; state <= IDLE; sum <= 0.
- No bubbles:
  - With out_ready held high, the trailer bytes follow the last body byte back-to-back.
  - Total output = N body bytes + 7 trailer bytes.
- Earliest next message: the block can accept in_start in the cycle after the SOH transfer.
- Sum width: exactly 8 bits; carries are discarded.
- Reset mid-message or mid-trailer:
  - Output is truncated immediately.
  - checksum_o clears to 0.
  - No checksum_valid_o pulse is produced.

Test Plan:
- Single-beat message: in_data=0x01 with in_start=in_end=1, out_ready=1 -> out: 01 31 30 3D 30 30 31 01 on consecutive cycles; checksum_o=0x01; one checksum_valid_o pulse.
- Body "AB<SOH>" (0x41,0x42,0x01) -> sum 0x84=132 -> trailer 31 30 3D 31 33 32 01; checksum_o=0x84.
- Wrap: body 0xFF,0xFF,0x04 -> sum 0x202 mod 256=0x02 -> trailer digits 30 30 32; checksum_o=0x02.
- Backpressure: repeat the "AB<SOH>" case with out_ready toggling 1,0,0,1...:
  - out_data stable while stalled.
  - in_ready=0 whenever out_valid&!out_ready.
  - Same 10-byte output sequence, no loss or duplication.
- Stray byte plus back-to-back messages:
  - in_valid with in_start=0 in IDLE is dropped.
  - Two consecutive messages: the second in_start is accepted the cycle after the first trailer's SOH; each message gets its own correct checksum.
- Reset asserted during trailer index 3 -> out_valid=0, checksum_o=0 immediately; no pulse; after release the next message produces a correct full trailer.
